// File: rtl/rom_loader.sv
// Writes a framed byte stream into the Hack instruction ROM, holding the CPU until the image checks out.
// Define ROM_LOADER_BOOT_HOLD_EN to keep the CPU held from power-up until the first good load.
module rom_loader #(
    parameter int         ADDR_W   = 15,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        rom_we,
    output logic [15:0] rom_addr,
    output logic [15:0] rom_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam logic [16:0] CAPACITY  = 17'd1 << ADDR_W;
    localparam logic [15:0] ADDR_MASK = CAPACITY[15:0] - 16'd1;

`ifdef ROM_LOADER_BOOT_HOLD_EN
    localparam logic HOLD_RST = 1'b1;
`else
    localparam logic HOLD_RST = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        CHK
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  chk_q, chk_d;
    logic        ready_q;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] wl_q, wl_d;

    logic        accept;
    logic [15:0] n_rx;
    logic [15:0] wl_next;

    assign accept  = in_valid && ready_q;
    assign n_rx    = {count_q[15:8], in_data};
    assign wl_next = wl_q + 16'd1;

    // Errors resolve inside the accepting cycle: flag raised, hold kept, straight back to IDLE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_hi_d = data_hi_q;
        chk_d     = chk_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        err_d     = err_q;
        wl_d      = wl_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_data == HDR_BYTE) begin
                        state_d = CNT_HI;
                        hold_d  = 1'b1;
                        err_d   = 1'b0;
                        chk_d   = 8'h00;
                        wl_d    = 16'd0;
                    end
                end
                CNT_HI: begin
                    count_d = {in_data, 8'h00};
                    chk_d   = chk_q ^ in_data;
                    state_d = CNT_LO;
                end
                CNT_LO: begin
                    count_d = n_rx;
                    chk_d   = chk_q ^ in_data;
                    if (n_rx == 16'd0) begin
                        state_d = CHK;
                    end else if ({1'b0, n_rx} > CAPACITY) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
                DATA_HI: begin
                    data_hi_d = in_data;
                    chk_d     = chk_q ^ in_data;
                    state_d   = DATA_LO;
                end
                DATA_LO: begin
                    chk_d   = chk_q ^ in_data;
                    we_d    = 1'b1;
                    wdata_d = {data_hi_q, in_data};
                    addr_d  = wl_q & ADDR_MASK;
                    wl_d    = wl_next;
                    state_d = (wl_next == count_q) ? CHK : DATA_HI;
                end
                CHK: begin
                    if (in_data == chk_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 16'd0;
            data_hi_q <= 8'h00;
            chk_q     <= 8'h00;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            hold_q    <= HOLD_RST;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wl_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            data_hi_q <= data_hi_d;
            chk_q     <= chk_d;
            ready_q   <= 1'b1;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wl_q      <= wl_d;
        end
    end

    assign in_ready     = ready_q;
    assign rom_we       = we_q;
    assign rom_addr     = addr_q;
    assign rom_wdata    = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: two instances (ADDR_W=4 and default) share one byte stream and are
// checked against a frame-level model plus hand-computed expectations. Honours ROM_LOADER_BOOT_HOLD_EN.
module tb_rom_loader;

`ifdef ROM_LOADER_BOOT_HOLD_EN
    localparam logic HOLD_RST = 1'b1;
`else
    localparam logic HOLD_RST = 1'b0;
`endif
    localparam logic [7:0] HDR = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;

    logic [1:0]       rdy_w, we_w, hold_w, done_w, err_w;
    logic [1:0][15:0] addr_w, wdata_w, wl_w;

    rom_loader #(.ADDR_W(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_w[0]), .rom_we(we_w[0]), .rom_addr(addr_w[0]), .rom_wdata(wdata_w[0]),
        .cpu_hold(hold_w[0]), .load_done(done_w[0]), .load_err(err_w[0]), .words_loaded(wl_w[0])
    );

    rom_loader dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_w[1]), .rom_we(we_w[1]), .rom_addr(addr_w[1]), .rom_wdata(wdata_w[1]),
        .cpu_hold(hold_w[1]), .load_done(done_w[1]), .load_err(err_w[1]), .words_loaded(wl_w[1])
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // frame-level model state
    logic             model_on;
    logic             exp_ready;
    logic [1:0]       exp_we, exp_done, exp_hold, exp_err;
    logic [1:0][15:0] exp_addr, exp_wdata, exp_wl;
    logic [15:0]      frame_words [32];

    // observed write / done log
    int          wcnt [2];
    int          dcnt [2];
    logic [15:0] wlog_addr [2][64];
    logic [15:0] wlog_data [2][64];
    logic [7:0]  raw_q [$];

    function automatic void check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, expected %0h", name, m, act, exp);
    endfunction

    function automatic int cap_of(input int m);
        return (m == 0) ? 16 : 32768;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (we_w[m] === 1'b1) begin
                if (wcnt[m] < 64) begin
                    wlog_addr[m][wcnt[m]] = addr_w[m];
                    wlog_data[m][wcnt[m]] = wdata_w[m];
                end
                wcnt[m]++;
            end
            if (done_w[m] === 1'b1) dcnt[m]++;
            if (model_on) begin
                check("in_ready", m, 32'(rdy_w[m]), 32'(exp_ready));
                check("rom_we", m, 32'(we_w[m]), 32'(exp_we[m]));
                check("load_done", m, 32'(done_w[m]), 32'(exp_done[m]));
                check("load_err", m, 32'(err_w[m]), 32'(exp_err[m]));
                check("cpu_hold", m, 32'(hold_w[m]), 32'(exp_hold[m]));
                check("words_loaded", m, 32'(wl_w[m]), 32'(exp_wl[m]));
                if (exp_we[m]) begin
                    check("rom_addr", m, 32'(addr_w[m]), 32'(exp_addr[m]));
                    check("rom_wdata", m, 32'(wdata_w[m]), 32'(exp_wdata[m]));
                end
            end
        end
    end

    task automatic tick(input logic v, input logic [7:0] b);
        in_valid = v;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        exp_ready = 1'b1;
        exp_we    = 2'b00;
        exp_done  = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'($urandom));
    endtask

    task automatic reset_assert();
        reset     = 1'b0;
        exp_ready = 1'b0;
        exp_we    = 2'b00;
        exp_done  = 2'b00;
        exp_err   = 2'b00;
        exp_hold  = {HOLD_RST, HOLD_RST};
        exp_wl    = '0;
    endtask

    task automatic reset_release();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);
    endtask

    task automatic clr();
        for (int m = 0; m < 2; m++) begin
            wcnt[m] = 0;
            dcnt[m] = 0;
        end
    endtask

    // every raw byte is followed by an in_valid=0 cycle
    task automatic send_raw();
        foreach (raw_q[i]) begin
            tick(1'b1, raw_q[i]);
            tick(1'b0, 8'($urandom));
        end
        raw_q.delete();
    endtask

    task automatic expect_m(input string tag, input int m, input logic hold, input logic err,
                            input logic [15:0] wl, input int nw, input int nd);
        check({tag, ".cpu_hold"}, m, 32'(hold_w[m]), 32'(hold));
        check({tag, ".load_err"}, m, 32'(err_w[m]), 32'(err));
        check({tag, ".words_loaded"}, m, 32'(wl_w[m]), 32'(wl));
        check({tag, ".we_count"}, m, 32'(wcnt[m]), 32'(nw));
        check({tag, ".done_count"}, m, 32'(dcnt[m]), 32'(nd));
    endtask

    task automatic expect_wr(input string tag, input int m, input int idx, input logic [15:0] a, input logic [15:0] d);
        check({tag, ".addr"}, m, 32'(wlog_addr[m][idx]), 32'(a));
        check({tag, ".data"}, m, 32'(wlog_data[m][idx]), 32'(d));
    endtask

    task automatic expect_reset_vals(input string tag);
        for (int m = 0; m < 2; m++) begin
            check({tag, ".in_ready"}, m, 32'(rdy_w[m]), 32'(0));
            check({tag, ".rom_we"}, m, 32'(we_w[m]), 32'(0));
            check({tag, ".rom_addr"}, m, 32'(addr_w[m]), 32'(0));
            check({tag, ".rom_wdata"}, m, 32'(wdata_w[m]), 32'(0));
            check({tag, ".cpu_hold"}, m, 32'(hold_w[m]), 32'(HOLD_RST));
            check({tag, ".load_done"}, m, 32'(done_w[m]), 32'(0));
            check({tag, ".load_err"}, m, 32'(err_w[m]), 32'(0));
            check({tag, ".words_loaded"}, m, 32'(wl_w[m]), 32'(0));
        end
    endtask

    // Frame-level model: the effect of each byte follows from its position in the frame.
    task automatic send_frame(input int n, input logic corrupt, input int gapmax);
        logic [7:0] chk;
        logic [7:0] b;
        logic [1:0] act;
        chk = 8'h00;
        act = 2'b11;
        idle(int'($urandom_range(0, gapmax)));
        tick(1'b1, HDR);
        exp_hold = 2'b11;
        exp_err  = 2'b00;
        exp_wl   = '0;
        b = 8'(n >> 8);
        idle(int'($urandom_range(0, gapmax)));
        tick(1'b1, b);
        chk ^= b;
        b = 8'(n);
        idle(int'($urandom_range(0, gapmax)));
        tick(1'b1, b);
        chk ^= b;
        for (int m = 0; m < 2; m++)
            if (n > cap_of(m)) begin
                exp_err[m] = 1'b1;
                act[m]     = 1'b0;
            end
        if (act == 2'b00) return;
        for (int i = 0; i < n; i++) begin
            b = frame_words[i][15:8];
            idle(int'($urandom_range(0, gapmax)));
            tick(1'b1, b);
            chk ^= b;
            b = frame_words[i][7:0];
            idle(int'($urandom_range(0, gapmax)));
            tick(1'b1, b);
            chk ^= b;
            for (int m = 0; m < 2; m++)
                if (act[m]) begin
                    exp_we[m]    = 1'b1;
                    exp_addr[m]  = 16'(i);
                    exp_wdata[m] = frame_words[i];
                    exp_wl[m]    = 16'(i + 1);
                end
        end
        b = corrupt ? (chk ^ 8'h01) : chk;
        idle(int'($urandom_range(0, gapmax)));
        tick(1'b1, b);
        for (int m = 0; m < 2; m++)
            if (act[m]) begin
                if (corrupt) exp_err[m] = 1'b1;
                else begin
                    exp_done[m] = 1'b1;
                    exp_hold[m] = 1'b0;
                end
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_on = 1'b1;
        clr();
        #2;
        reset_assert();
        reset_release();
        for (int m = 0; m < 2; m++) begin
            check("por.in_ready", m, 32'(rdy_w[m]), 32'(1));
            expect_m("por", m, HOLD_RST, 1'b0, 16'd0, 0, 0);
        end
        model_on = 1'b0;

        // junk and an un-valid header must not start a frame
        tick(1'b1, 8'h00);
        tick(1'b0, HDR);
        tick(1'b1, 8'hFF);
        tick(1'b0, 8'h00);
        for (int m = 0; m < 2; m++) check("junk.cpu_hold", m, 32'(hold_w[m]), 32'(HOLD_RST));
        tick(1'b1, HDR);
        for (int m = 0; m < 2; m++) check("hdr.cpu_hold", m, 32'(hold_w[m]), 32'(1));
        tick(1'b0, 8'h00);
        raw_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_raw();
        idle(2);
        for (int m = 0; m < 2; m++) begin
            expect_m("good", m, 1'b0, 1'b0, 16'd2, 2, 1);
            expect_wr("good.w0", m, 0, 16'd0, 16'h1234);
            expect_wr("good.w1", m, 1, 16'd1, 16'hABCD);
        end

        clr();
        raw_q = '{HDR, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_raw();
        idle(2);
        for (int m = 0; m < 2; m++) begin
            expect_m("badchk", m, 1'b1, 1'b1, 16'd2, 2, 0);
            expect_wr("badchk.w1", m, 1, 16'd1, 16'hABCD);
        end

        clr();
        raw_q = '{HDR, 8'h00, 8'h00, 8'h00};
        send_raw();
        idle(2);
        for (int m = 0; m < 2; m++) expect_m("empty", m, 1'b0, 1'b0, 16'd0, 0, 1);

        // 17 words: too many for ADDR_W=4, fine for the default instance
        clr();
        raw_q = '{HDR, 8'h00, 8'h11};
        send_raw();
        check("ovf.load_err", 0, 32'(err_w[0]), 32'(1));
        check("ovf.cpu_hold", 0, 32'(hold_w[0]), 32'(1));
        for (int i = 0; i < 34; i++) raw_q.push_back(8'h00);
        raw_q.push_back(8'h11);
        send_raw();
        idle(2);
        expect_m("ovf", 0, 1'b1, 1'b1, 16'd0, 0, 0);
        expect_m("ovf", 1, 1'b0, 1'b0, 16'd17, 17, 1);
        expect_wr("ovf.w16", 1, 16, 16'd16, 16'h0000);

        clr();
        raw_q = '{HDR, 8'h80, 8'h01};
        send_raw();
        idle(2);
        for (int m = 0; m < 2; m++) expect_m("ovf8001", m, 1'b1, 1'b1, 16'd0, 0, 0);

        clr();
        raw_q = '{HDR, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_raw();
        reset_assert();
        #1;
        expect_reset_vals("midrst");
        reset_release();
        for (int m = 0; m < 2; m++) check("midrst.we_count", m, 32'(wcnt[m]), 32'(1));
        clr();
        raw_q = '{HDR, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_raw();
        idle(2);
        for (int m = 0; m < 2; m++) begin
            expect_m("reload", m, 1'b0, 1'b0, 16'd2, 2, 1);
            expect_wr("reload.w0", m, 0, 16'd0, 16'h1234);
            expect_wr("reload.w1", m, 1, 16'd1, 16'hABCD);
        end

        // randomized frames against the cycle model
        reset_assert();
        model_on = 1'b1;
        reset_release();
        for (int f = 0; f < 40; f++) begin
            int         n;
            int         sel;
            logic       corrupt;
            logic [7:0] g;
            sel = int'($urandom_range(0, 9));
            n = (sel == 0) ? int'($urandom_range(17, 20)) : (sel == 1) ? 16 : int'($urandom_range(0, 15));
            corrupt = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) begin
                frame_words[i] = 16'($urandom);
                if (n > 16) frame_words[i] = frame_words[i] & 16'h7F7F;
            end
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == HDR) g = 8'h5A;
                tick(1'b1, g);
            end
            send_frame(n, corrupt, 2);
        end
        idle(3);
        model_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
